// File: rtl/seven_seg_pkg.sv
// Shared types and segment constants for the seven-segment bus reader.
// Segment bit order: bit0=a ... bit6=g, active-high.
package seven_seg_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] nibble_t;

  localparam seg_t SEG_0 = 7'h3F;
  localparam seg_t SEG_1 = 7'h06;
  localparam seg_t SEG_2 = 7'h5B;
  localparam seg_t SEG_3 = 7'h4F;
  localparam seg_t SEG_4 = 7'h66;
  localparam seg_t SEG_5 = 7'h6D;
  localparam seg_t SEG_6 = 7'h7D;
  localparam seg_t SEG_7 = 7'h07;
  localparam seg_t SEG_8 = 7'h7F;
  localparam seg_t SEG_9 = 7'h6F;
  localparam seg_t SEG_A = 7'h77;
  localparam seg_t SEG_B = 7'h7C;
  localparam seg_t SEG_C = 7'h39;
  localparam seg_t SEG_D = 7'h5E;
  localparam seg_t SEG_E = 7'h79;
  localparam seg_t SEG_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURED
  } reader_state_t;

endpackage

// File: rtl/seven_seg_reader_if.sv
// Frame output channel of the seven-segment reader: valid/ready plus the
// recovered digits, per-digit error flags and the overrun pulse.
interface seven_seg_reader_if #(
  parameter int NUM_DIGITS = 4
) ();

  logic                    frame_valid;
  logic                    frame_ready;
  logic [4*NUM_DIGITS-1:0] frame_digits;
  logic [NUM_DIGITS-1:0]   frame_err;
  logic                    overrun;

  modport master (
    output frame_valid,
    output frame_digits,
    output frame_err,
    output overrun,
    input  frame_ready
  );

  modport slave (
    input  frame_valid,
    input  frame_digits,
    input  frame_err,
    input  overrun,
    output frame_ready
  );

endinterface

// File: rtl/seg_pattern_to_nibble.sv
// Combinational segment-pattern to digit lookup. Hex letters A-F are
// recognised only when SEVEN_SEG_READER_HEX_EN is defined.
module seg_pattern_to_nibble
  import seven_seg_pkg::*;
(
  input  seg_t    seg,
  output nibble_t nibble,
  output logic    err
);

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    nibble = 4'h0;
    err    = 1'b0;
    case (seg)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
`ifdef SEVEN_SEG_READER_HEX_EN
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_reader.sv
// Recovers digit values from a multiplexed seven-segment bus and emits one
// frame per complete scan. Optional hex decoding: SEVEN_SEG_READER_HEX_EN.
module seven_seg_reader
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  seg_t                  seg_in,
  input  logic [NUM_DIGITS-1:0] dig_sel_in,
  seven_seg_reader_if.master    frame_if
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  seg_t                    s_seg, p_seg;
  logic [NUM_DIGITS-1:0]   s_sel, p_sel;
  reader_state_t           state, next_state;
  logic [CNT_W-1:0]        cnt, next_cnt;
  logic                    capture;
  logic                    changed;
  logic                    sel_onehot;
  logic                    sel_multi;
  logic [IDX_W-1:0]        sel_idx;
  nibble_t                 lookup_nib;
  logic                    lookup_err;
  logic [NUM_DIGITS-1:0]   seen;
  logic [NUM_DIGITS-1:0]   cap_mask;
  logic                    complete;
  logic [4*NUM_DIGITS-1:0] slot_digits;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic                    frame_valid_q;
  logic [4*NUM_DIGITS-1:0] frame_digits_q;
  logic [NUM_DIGITS-1:0]   frame_err_q;
  logic                    overrun_q;

  // p_* holds the previous registered sample so stability is judged on
  // the synchronised copy only.
  // NOTE: sequential state uses non-blocking assignments throughout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_seg <= '0;
      s_sel <= '0;
      p_seg <= '0;
      p_sel <= '0;
    end else begin
      s_seg <= seg_in;
      s_sel <= dig_sel_in;
      p_seg <= s_seg;
      p_sel <= s_sel;
    end
  end

  assign changed = ({s_seg, s_sel} != {p_seg, p_sel});

  always_comb begin
    sel_onehot = 1'b0;
    sel_multi  = 1'b0;
    sel_idx    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_sel[i]) begin
        if (sel_onehot) sel_multi = 1'b1;
        sel_onehot = 1'b1;
        sel_idx    = IDX_W'(i);
      end
    end
    sel_onehot = sel_onehot & ~sel_multi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        if (sel_onehot) begin
          next_state = SETTLE;
          next_cnt   = CNT_W'(1);
        end else begin
          next_cnt = '0;
        end
      end
      SETTLE, CAPTURED: begin
        if (changed) begin
          next_state = sel_onehot ? SETTLE : IDLE;
          next_cnt   = sel_onehot ? CNT_W'(1) : '0;
        end else if (state == SETTLE) begin
          next_cnt = cnt + CNT_W'(1);
          if (cnt == CNT_W'(STABLE_CYCLES - 1)) begin
            capture    = 1'b1;
            next_state = CAPTURED;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = '0;
      end
    endcase
  end

  seg_pattern_to_nibble u_lookup (
    .seg    (s_seg),
    .nibble (lookup_nib),
    .err    (lookup_err)
  );

  // NOTE: the digit slots are small registers and are reset like the rest,
  // so a frame can never expose uninitialised data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_digits <= '0;
      slot_err    <= '0;
    end else if (capture) begin
      slot_digits[4*sel_idx +: 4] <= lookup_nib;
      slot_err[sel_idx]           <= lookup_err;
    end
  end

  assign complete = &seen;
  assign cap_mask = NUM_DIGITS'(capture) << sel_idx;

  // A capture on the completion edge belongs to the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen           <= '0;
      frame_valid_q  <= 1'b0;
      frame_digits_q <= '0;
      frame_err_q    <= '0;
      overrun_q      <= 1'b0;
    end else begin
      seen      <= (complete ? '0 : seen) | cap_mask;
      overrun_q <= 1'b0;
      if (complete) begin
        if (!frame_valid_q || frame_if.frame_ready) begin
          frame_valid_q  <= 1'b1;
          frame_digits_q <= slot_digits;
          frame_err_q    <= slot_err;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (frame_valid_q && frame_if.frame_ready) begin
        frame_valid_q <= 1'b0;
      end
    end
  end

  assign frame_if.frame_valid  = frame_valid_q;
  assign frame_if.frame_digits = frame_digits_q;
  assign frame_if.frame_err    = frame_err_q;
  assign frame_if.overrun      = overrun_q;

endmodule

// File: tb/tb_seven_seg_reader.sv
// Directed bench for seven_seg_reader: reset, nominal scan, glitch rejection,
// backpressure/overrun, simultaneous accept+load and bad patterns.
module tb_seven_seg_reader;

  logic       clk;
  logic       rst_n;
  logic [6:0] seg_in;
  logic [3:0] dig_sel_in;
  int         total;
  int         bad;
  int         ov_count;

  seven_seg_reader_if #(.NUM_DIGITS(4)) frame_if ();

  seven_seg_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seg_in     (seg_in),
    .dig_sel_in (dig_sel_in),
    .frame_if   (frame_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (frame_if.overrun === 1'b1) ov_count++;

  task automatic hold(input logic [3:0] sel, input logic [6:0] pattern, input int n);
    @(negedge clk);
    dig_sel_in = sel;
    seg_in     = pattern;
    repeat (n) @(posedge clk);
  endtask

  task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                      input logic [6:0] d2, input logic [6:0] d3);
    hold(4'b0001, d0, 6);
    hold(4'b0010, d1, 6);
    hold(4'b0100, d2, 6);
    hold(4'b1000, d3, 6);
    hold(4'b0000, 7'h00, 3);
    @(negedge clk);
  endtask

  task automatic accept();
    @(negedge clk);
    frame_if.frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_if.frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++;
    if (frame_if.frame_valid !== 1'b0 || frame_if.frame_digits !== 16'h0000) begin
      bad++;
      $display("FAIL reset_poweron: valid=%b digits=%h, want 0/0000",
               frame_if.frame_valid, frame_if.frame_digits);
    end
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    total++;
    if (frame_if.frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL reset_preframe: valid=%b, want 1", frame_if.frame_valid);
    end
    hold(4'b0001, 7'h06, 6);
    hold(4'b0010, 7'h5B, 6);
    @(negedge clk);
    rst_n      = 1'b0;
    dig_sel_in = 4'b0000;
    seg_in     = 7'h00;
    @(negedge clk);
    total++;
    if (frame_if.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_valid: got %b, want 0", frame_if.frame_valid);
    end
    total++;
    if (frame_if.frame_digits !== 16'h0000 || frame_if.frame_err !== 4'b0000) begin
      bad++;
      $display("FAIL reset_data: digits=%h err=%b, want 0000/0000",
               frame_if.frame_digits, frame_if.frame_err);
    end
    total++;
    if (frame_if.overrun !== 1'b0) begin
      bad++;
      $display("FAIL reset_overrun: got %b, want 0", frame_if.overrun);
    end
    rst_n = 1'b1;
    hold(4'b0100, 7'h4F, 6);
    hold(4'b1000, 7'h66, 6);
    hold(4'b0000, 7'h00, 4);
    @(negedge clk);
    total++;
    if (frame_if.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_partial_lost: valid=%b, want 0", frame_if.frame_valid);
    end
  endtask

  task automatic test_nominal();
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    total++;
    if (frame_if.frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL nominal_valid: got %b, want 1", frame_if.frame_valid);
    end
    total++;
    if (frame_if.frame_digits !== 16'h4321) begin
      bad++;
      $display("FAIL nominal_digits: got %h, want 4321", frame_if.frame_digits);
    end
    total++;
    if (frame_if.frame_err !== 4'b0000) begin
      bad++;
      $display("FAIL nominal_err: got %b, want 0000", frame_if.frame_err);
    end
    accept();
    total++;
    if (frame_if.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL nominal_accept: valid=%b, want 0", frame_if.frame_valid);
    end
  endtask

  task automatic test_glitch();
    hold(4'b0001, 7'h06, 6);
    hold(4'b0100, 7'h4F, 6);
    hold(4'b0011, 7'h06, 10);
    hold(4'b1000, 7'h7F, 3);
    hold(4'b0000, 7'h00, 3);
    @(negedge clk);
    total++;
    if (frame_if.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL glitch_nocapture: valid=%b, want 0", frame_if.frame_valid);
    end
    hold(4'b1000, 7'h66, 6);
    hold(4'b0010, 7'h7F, 3);
    hold(4'b0010, 7'h6D, 6);
    hold(4'b0000, 7'h00, 3);
    @(negedge clk);
    total++;
    if (frame_if.frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL glitch_valid: got %b, want 1", frame_if.frame_valid);
    end
    total++;
    if (frame_if.frame_digits !== 16'h4351) begin
      bad++;
      $display("FAIL glitch_digits: got %h, want 4351", frame_if.frame_digits);
    end
    accept();
  endtask

  task automatic test_backpressure();
    ov_count = 0;
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    total++;
    if (frame_if.frame_valid !== 1'b1 || frame_if.frame_digits !== 16'h4321) begin
      bad++;
      $display("FAIL bp_first: valid=%b digits=%h, want 1/4321",
               frame_if.frame_valid, frame_if.frame_digits);
    end
    scan(7'h6D, 7'h7D, 7'h07, 7'h7F);
    total++;
    if (ov_count !== 1) begin
      bad++;
      $display("FAIL bp_overrun_pulses: got %0d, want 1", ov_count);
    end
    total++;
    if (frame_if.frame_digits !== 16'h4321) begin
      bad++;
      $display("FAIL bp_held_digits: got %h, want 4321", frame_if.frame_digits);
    end
    total++;
    if (frame_if.frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL bp_held_valid: got %b, want 1", frame_if.frame_valid);
    end
    accept();
    total++;
    if (frame_if.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_accept: valid=%b, want 0", frame_if.frame_valid);
    end
  endtask

  task automatic test_back_to_back();
    scan(7'h06, 7'h5B, 7'h4F, 7'h66);
    ov_count = 0;
    hold(4'b0001, 7'h07, 6);
    hold(4'b0010, 7'h7F, 6);
    hold(4'b0100, 7'h6F, 6);
    @(negedge clk);
    dig_sel_in = 4'b1000;
    seg_in     = 7'h3F;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++;
    if (frame_if.frame_valid !== 1'b1 || frame_if.frame_digits !== 16'h4321) begin
      bad++;
      $display("FAIL b2b_before: valid=%b digits=%h, want 1/4321",
               frame_if.frame_valid, frame_if.frame_digits);
    end
    frame_if.frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    frame_if.frame_ready = 1'b0;
    dig_sel_in           = 4'b0000;
    seg_in               = 7'h00;
    total++;
    if (frame_if.frame_valid !== 1'b1) begin
      bad++;
      $display("FAIL b2b_valid: got %b, want 1", frame_if.frame_valid);
    end
    total++;
    if (frame_if.frame_digits !== 16'h0987) begin
      bad++;
      $display("FAIL b2b_digits: got %h, want 0987", frame_if.frame_digits);
    end
    total++;
    if (ov_count !== 0) begin
      bad++;
      $display("FAIL b2b_overrun: got %0d pulses, want 0", ov_count);
    end
    accept();
    total++;
    if (frame_if.frame_valid !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: valid=%b, want 0", frame_if.frame_valid);
    end
  endtask

  task automatic test_bad_pattern();
    logic [15:0] exp_digits;
    logic [3:0]  exp_err;
    scan(7'h06, 7'h5B, 7'h00, 7'h66);
    total++;
    if (frame_if.frame_err !== 4'b0100) begin
      bad++;
      $display("FAIL bad_blank_err: got %b, want 0100", frame_if.frame_err);
    end
    total++;
    if (frame_if.frame_digits !== 16'h4021) begin
      bad++;
      $display("FAIL bad_blank_digits: got %h, want 4021", frame_if.frame_digits);
    end
    accept();
`ifdef SEVEN_SEG_READER_HEX_EN
    exp_digits = 16'h4A21;
    exp_err    = 4'b0000;
`else
    exp_digits = 16'h4021;
    exp_err    = 4'b0100;
`endif
    scan(7'h06, 7'h5B, 7'h77, 7'h66);
    total++;
    if (frame_if.frame_err !== exp_err) begin
      bad++;
      $display("FAIL hex_a_err: got %b, want %b", frame_if.frame_err, exp_err);
    end
    total++;
    if (frame_if.frame_digits !== exp_digits) begin
      bad++;
      $display("FAIL hex_a_digits: got %h, want %h", frame_if.frame_digits, exp_digits);
    end
    accept();
  endtask

  initial begin
    total                = 0;
    bad                  = 0;
    ov_count             = 0;
    rst_n                = 1'b0;
    seg_in               = 7'h00;
    dig_sel_in           = 4'b0000;
    frame_if.frame_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    test_reset();
    test_nominal();
    test_glitch();
    test_backpressure();
    test_back_to_back();
    test_bad_pattern();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_reader.md
Name: seven_seg_reader

Overview:
Receive-side counterpart of the segment decoder. Monitors a multiplexed seven-segment display bus (active-high segments plus one-hot digit select) and recovers the hex/BCD value of every digit position. Each complete scan is presented as one frame on a valid/ready interface. Used for self-checking display paths and for reading display-formatted data back into logic.

Parameters:
NUM_DIGITS, 4, number of multiplexed digit positions (≥1)
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (≥2)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
seg_in  input  7  segment bus, bit0=a … bit6=g, active-high; synchronous to clk
dig_sel_in  input  NUM_DIGITS  digit enable, one-hot active-high, bit i = digit i
frame_ready  input  1  consumer accepts the frame when high with frame_valid
frame_valid  output  1  frame_digits/frame_err hold a complete frame
frame_digits  output  4*NUM_DIGITS  digit i value at [4i+3:4i]
frame_err  output  NUM_DIGITS  bit i set: digit i pattern was unrecognised (its nibble = 0)
overrun  output  1  one-cycle pulse: completed frame dropped because output was still full

Behaviour:
- Reset (async assert, synchronous release): frame_valid=0, frame_digits=0, frame_err=0, overrun=0, seen mask=0, stability counter=0, FSM=IDLE.
- Inputs pass through one register stage (s_seg, s_sel); all decisions use the registered copy.
- FSM per stable episode:
  - IDLE: s_sel is not one-hot (zero or multiple bits). Counter=0. Go to SETTLE when s_sel is one-hot.
  - SETTLE: counter increments while {s_seg,s_sel} equals the previous sample. Any change resets the counter to 1 (new episode, stays SETTLE), or goes to IDLE if the new s_sel is not one-hot. When the counter reaches STABLE_CYCLES, capture on that edge and go to CAPTURED.
  - CAPTURED: no further captures. Any change to {s_seg,s_sel} goes to SETTLE (counter=1) or IDLE.
- Capture: pattern lookup gives nibble and err. Store in digit slot i (i = index of s_sel). Set seen[i]. Recapturing a slot already seen overwrites it with the latest value.
- Recognised patterns: 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9. All others give nibble 0 and err 1.
- Frame completion: the edge after seen becomes all ones.
  - If frame_valid=0, or frame_valid&frame_ready on that same edge: load frame_digits/frame_err, frame_valid=1.
  - Otherwise: overrun pulses for 1 cycle, the frame is dropped, and the held frame is unchanged.
  - seen clears on completion in both cases. The digit slots are not cleared.
- Handshake: frame_valid stays high and data stays stable until frame_valid&frame_ready. frame_valid drops the edge after acceptance unless a new frame loads on the same edge (then frame_valid stays 1 and data updates).
- Latency: capture occurs STABLE_CYCLES+1 edges after the input first presents the pattern. frame_valid rises 1 edge after the last missing digit is captured.
- rst_n asserted mid-frame or mid-handshake: immediate return to the reset state; the partial frame is lost and no overrun is raised.

Optional Feature:
SEVEN_SEG_READER_HEX_EN
- Defined: the lookup also accepts 0x77→A, 0x7C→b, 0x39→C, 0x5E→d, 0x79→E, 0x71→F with err=0.
- Undefined: those six patterns give err=1 and nibble 0.

Decomposition:
- Package seven_seg_pkg:
  - typedef seg_t (logic [6:0]) and nibble_t (logic [3:0])
  - constants SEG_0…SEG_9, SEG_A…SEG_F
  - FSM enum reader_state_t {IDLE, SETTLE, CAPTURED}
- Sub-module seg_pattern_to_nibble: purely combinational lookup (seg_t in → nibble_t, err out), honouring the macro. seven_seg_reader instantiates it once.

Test Plan:
- Reset: drive digits 0–1 of a scan, pulse rst_n low for 1 cycle → all outputs 0; completing digits 2–3 alone produces no frame.
- Nominal scan: sel=0001/seg=0x06, 0010/0x5B, 0100/0x4F, 1000/0x66, each held 6 cycles → frame_valid=1, frame_digits=16'h4321, frame_err=0; frame_ready=1 → frame_valid low next edge.
- Glitch rejection: sel=0010/seg=0x7F held 3 cycles, then 0010/0x6D held 6 → slot 1 = 5. Also sel=0011 held 10 cycles → no capture.
- Backpressure: frame_ready=0, complete two scans (4321 then 8765) → overrun single pulse at second completion, frame_digits stays 16'h4321. Raise frame_ready → valid drops.
- Simultaneous: frame_ready=1 on the exact edge a second frame 16'h0987 completes → frame_valid stays 1, data=16'h0987, overrun=0.
- Bad pattern: digit 2 seg=0x00 → frame_err=4'b0100 and nibble 0. Digit 2 seg=0x77 → nibble A, err 0 with SEVEN_SEG_READER_HEX_EN; err bit 2 set without it.
